// File: rtl/if_stage.sv
// Instruction-fetch stage: issues nextpc to a synchronous instruction SRAM and hands {pc, inst} to decode.
// Optional misaligned-fetch detection is enabled with `define FS_ADEF_CHECK_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [33:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic        fs_adef_err
);

  // Handshake: a stage transfers on any edge where the producer's valid and the consumer's allowin are both high.
  logic        r_fs_valid;
  logic [31:0] r_fs_pc;
  logic        r_buf_valid;
  logic [31:0] r_buf_inst;

  logic        w_br_stall;
  logic        w_br_taken;
  logic [31:0] w_br_target;
  logic [31:0] w_seq_pc;
  logic [31:0] w_nextpc;
  logic        w_to_fs_valid;
  logic        w_fs_ready_go;
  logic        w_fs_allowin;
  logic        w_accept;
  logic [31:0] w_raw_inst;
  logic [31:0] w_fs_inst;

  assign w_br_stall    = br_bus[33];
  assign w_br_taken    = br_bus[32];
  assign w_br_target   = br_bus[31:0];
  assign w_seq_pc      = r_fs_pc + 32'd4;
  assign w_nextpc      = w_br_taken ? w_br_target : w_seq_pc;
  assign w_to_fs_valid = ~reset & ~w_br_stall;
  assign w_fs_ready_go = 1'b1;
  assign w_fs_allowin  = ~r_fs_valid | (w_fs_ready_go & ds_allowin);
  assign w_accept      = w_to_fs_valid & w_fs_allowin;
  assign w_raw_inst    = r_buf_valid ? r_buf_inst : inst_sram_rdata;

  // Gated by reset so decode never sees a stale instruction during the flush cycle.
  assign fs_to_ds_valid  = r_fs_valid & w_fs_ready_go & ~reset;
  assign fs_to_ds_bus    = {r_fs_pc, w_fs_inst};
  assign inst_sram_we    = 4'b0;
  assign inst_sram_wdata = 32'b0;
  assign inst_sram_addr  = w_nextpc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fs_valid <= 1'b0;
      r_fs_pc    <= RESET_PC - 32'd4;
    end else if (w_accept) begin
      r_fs_valid <= 1'b1;
      r_fs_pc    <= w_nextpc;
    end else if (w_fs_allowin) begin
      r_fs_valid <= 1'b0;
    end
  end

  // Holds the SRAM output while decode back-pressures, since the SRAM does not keep its read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_valid <= 1'b0;
      r_buf_inst  <= 32'b0;
    end else if (w_accept) begin
      r_buf_valid <= 1'b0;
    end else if (r_fs_valid && !ds_allowin && !r_buf_valid) begin
      r_buf_valid <= 1'b1;
      r_buf_inst  <= inst_sram_rdata;
    end
  end

`ifdef FS_ADEF_CHECK_EN
  logic w_misaligned;
  logic r_fs_adef;
  logic r_adef_err;

  assign w_misaligned = (w_nextpc[1:0] != 2'b00);
  assign inst_sram_en = w_accept & ~w_misaligned;
  assign w_fs_inst    = r_fs_adef ? 32'h0 : w_raw_inst;
  assign fs_adef_err  = r_adef_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fs_adef  <= 1'b0;
      r_adef_err <= 1'b0;
    end else if (w_accept) begin
      r_fs_adef  <= w_misaligned;
      r_adef_err <= r_adef_err | w_misaligned;
    end
  end
`else
  assign inst_sram_en = w_accept;
  assign w_fs_inst    = w_raw_inst;
  assign fs_adef_err  = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: stream, back-pressure, redirect, stall, reset flush and misaligned fetch.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        ds_allowin;
  logic [33:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        fs_adef_err;

  int total;
  int bad;
  logic [31:0] garbage_cnt;

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .ds_allowin     (ds_allowin),
    .br_bus         (br_bus),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_we   (inst_sram_we),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .fs_adef_err    (fs_adef_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'ha5a50000;
  endfunction

  // SRAM model: output is only meaningful the cycle after an enabled read.
  always @(posedge clk) begin
    garbage_cnt <= garbage_cnt + 32'd1;
    if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
    else              inst_sram_rdata <= 32'hbad00000 | garbage_cnt;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ds, input logic [33:0] br);
    @(negedge clk);
    reset      = rst;
    ds_allowin = ds;
    br_bus     = br;
    #1;
  endtask

  function automatic logic [63:0] bus_of(input logic [31:0] pc);
    return {pc, mem_word(pc)};
  endfunction

  function automatic logic [33:0] br(input logic stall, input logic taken, input logic [31:0] tgt);
    return {stall, taken, tgt};
  endfunction

  logic [63:0] held_bus;
  logic        exp_adef;

  initial begin
    total = 0;
    bad = 0;
    garbage_cnt = 32'd0;
    inst_sram_rdata = 32'd0;
    reset = 1'b1;
    ds_allowin = 1'b1;
    br_bus = 34'd0;
`ifdef FS_ADEF_CHECK_EN
    exp_adef = 1'b1;
`else
    exp_adef = 1'b0;
`endif

    drive(1, 1, 34'd0);
    check("rst_valid", {63'd0, fs_to_ds_valid}, 64'd0);
    check("rst_en",    {63'd0, inst_sram_en}, 64'd0);
    check("rst_err",   {63'd0, fs_adef_err}, 64'd0);
    check("rst_we",    {60'd0, inst_sram_we}, 64'd0);
    drive(1, 1, 34'd0);
    check("rst_valid2", {63'd0, fs_to_ds_valid}, 64'd0);

    // first fetch after release
    drive(0, 1, 34'd0);
    check("first_en",    {63'd0, inst_sram_en}, 64'd1);
    check("first_addr",  {32'd0, inst_sram_addr}, 64'h1c000000);
    check("first_valid", {63'd0, fs_to_ds_valid}, 64'd0);
    drive(0, 1, 34'd0);
    check("s0_valid", {63'd0, fs_to_ds_valid}, 64'd1);
    check("s0_bus",   fs_to_ds_bus, bus_of(32'h1c000000));
    check("s0_addr",  {32'd0, inst_sram_addr}, 64'h1c000004);

    // back-pressure for three cycles while 1c000004 is held
    held_bus = bus_of(32'h1c000004);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 34'd0);
      check("bp_valid", {63'd0, fs_to_ds_valid}, 64'd1);
      check("bp_bus",   fs_to_ds_bus, held_bus);
      check("bp_en",    {63'd0, inst_sram_en}, 64'd0);
    end
    drive(0, 1, 34'd0);
    check("bp_rel_bus",  fs_to_ds_bus, held_bus);
    check("bp_rel_en",   {63'd0, inst_sram_en}, 64'd1);
    check("bp_rel_addr", {32'd0, inst_sram_addr}, 64'h1c000008);

    // taken branch while 1c000008 sits in IF
    drive(0, 1, br(0, 1, 32'h1c000100));
    check("br_bus_slot", fs_to_ds_bus, bus_of(32'h1c000008));
    check("br_valid",    {63'd0, fs_to_ds_valid}, 64'd1);
    check("br_addr",     {32'd0, inst_sram_addr}, 64'h1c000100);
    check("br_en",       {63'd0, inst_sram_en}, 64'd1);
    drive(0, 1, 34'd0);
    check("br_tgt_bus", fs_to_ds_bus, bus_of(32'h1c000100));
    check("br_seq_addr", {32'd0, inst_sram_addr}, 64'h1c000104);

    // load-use stall on a taken branch for two cycles
    held_bus = bus_of(32'h1c000104);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, br(1, 1, 32'h1c000200));
      check("st_en",    {63'd0, inst_sram_en}, 64'd0);
      check("st_bus",   fs_to_ds_bus, held_bus);
      check("st_valid", {63'd0, fs_to_ds_valid}, 64'd1);
    end
    drive(0, 1, br(0, 1, 32'h1c000200));
    check("st_drop_en",   {63'd0, inst_sram_en}, 64'd1);
    check("st_drop_addr", {32'd0, inst_sram_addr}, 64'h1c000200);
    check("st_drop_bus",  fs_to_ds_bus, held_bus);

    // fill the buffer, then reset on top of it
    drive(0, 0, 34'd0);
    check("pre_rst_bus", fs_to_ds_bus, bus_of(32'h1c000200));
    drive(1, 0, 34'd0);
    check("mid_rst_valid", {63'd0, fs_to_ds_valid}, 64'd0);
    check("mid_rst_en",    {63'd0, inst_sram_en}, 64'd0);
    drive(0, 1, 34'd0);
    check("post_rst_valid", {63'd0, fs_to_ds_valid}, 64'd0);
    check("post_rst_addr",  {32'd0, inst_sram_addr}, 64'h1c000000);
    check("post_rst_en",    {63'd0, inst_sram_en}, 64'd1);
    drive(0, 1, 34'd0);
    check("post_rst_bus",   fs_to_ds_bus, bus_of(32'h1c000000));

    // misaligned branch target
    drive(0, 1, br(0, 1, 32'h1c000102));
    check("adef_addr", {32'd0, inst_sram_addr}, 64'h1c000102);
    check("adef_en",   {63'd0, inst_sram_en}, {63'd0, ~exp_adef});
    check("adef_err0", {63'd0, fs_adef_err}, 64'd0);
    drive(0, 1, 34'd0);
    check("adef_valid", {63'd0, fs_to_ds_valid}, 64'd1);
    check("adef_bus",   fs_to_ds_bus,
          exp_adef ? {32'h1c000102, 32'h0} : bus_of(32'h1c000102));
    check("adef_err1",  {63'd0, fs_adef_err}, {63'd0, exp_adef});
    drive(0, 1, 34'd0);
    check("adef_pc_next", {32'd0, fs_to_ds_bus[63:32]}, 64'h1c000106);
    check("adef_err2",    {63'd0, fs_adef_err}, {63'd0, exp_adef});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage LoongArch pipeline, the producer of the IF→ID interface. It generates the next PC, issues reads to a synchronous instruction SRAM, and presents {pc, inst} to the decode stage under a valid/allowin handshake. It consumes the decode stage's branch bus for redirect and stall. It also buffers the SRAM read data so the instruction survives decode back-pressure.

## Interface
- RESET_PC, 32'h1c000000: first fetch address after reset.
- clk  input  1  pipeline clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- ds_allowin  input  1  decode stage accepts a new instruction this cycle.
- br_bus  input  34  {br_stall[33], br_taken[32], br_target[31:0]}, from decode.
- fs_to_ds_valid  output  1  fetch stage holds a valid instruction for decode.
- fs_to_ds_bus  output  64  {fs_pc[63:32], fs_inst[31:0]}.
- inst_sram_en  output  1  SRAM read enable.
- inst_sram_we  output  4  always 4'b0.
- inst_sram_addr  output  32  read address (nextpc).
- inst_sram_wdata  output  32  always 32'b0.
- inst_sram_rdata  input  32  read data, valid the cycle after the enable.
- fs_adef_err  output  1  sticky misaligned-fetch flag. Its behaviour is set under Configuration.

## Operation
- Pre-IF, combinational: seq_pc = fs_pc + 4, 32-bit wrap-around, no carry out. nextpc = br_taken ? br_target : seq_pc.
- to_fs_valid = ~reset & ~br_stall.
- inst_sram_en = to_fs_valid & fs_allowin, with inst_sram_addr = nextpc.
- fs_ready_go = 1. fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin). fs_to_ds_valid = fs_valid & fs_ready_go.
- Transfer to IF happens when to_fs_valid & fs_allowin. On that edge: fs_pc ← nextpc, fs_valid ← 1.
- If fs_allowin is 1 but to_fs_valid is 0: fs_valid ← 0.
- Instruction buffer (buf_valid, buf_inst) fills when fs_valid and ~ds_allowin and ~buf_valid. It captures inst_sram_rdata.
- buf_valid clears on any edge where IF accepts a new instruction.
- fs_inst = buf_valid ? buf_inst : inst_sram_rdata.
- Branch: the instruction in IF while br_taken is asserted is the slot that decode discards. IF still delivers it normally. The next fetch goes to br_target in that same accept cycle.
- br_stall (load-use on a taken branch): no fetch issued, fs_pc and fs_valid hold, and the buffer behaves as above.
- br_stall has priority over br_taken for issuing. The redirect takes effect on the first cycle stall drops, because decode still holds the branch.
- Simultaneous accept and ds_allowin: pass-through. The old instruction moves to ID and the new address is issued in the same cycle.

## Timing
- Reset values: fs_valid=0, fs_pc=RESET_PC-4, buf_valid=0, buf_inst=0, fs_adef_err=0.
- During reset: fs_to_ds_valid=0, inst_sram_en=0.
- First cycle after reset deasserts: inst_sram_en=1 and addr=RESET_PC. On the next cycle fs_to_ds_valid=1 with pc=RESET_PC.
- Fetch latency is 1 cycle from address issue to the {pc, inst} valid at the decode boundary. Throughput is 1 instruction/cycle with no stalls.
- Redirect penalty is 1 slot: the fall-through instruction, discarded by decode.
- Reset mid-operation flushes the IF contents and any pending buffer on the same edge. The SRAM read issued in the reset cycle is ignored.

## Configuration
- FS_ADEF_CHECK_EN, defined: when nextpc[1:0]≠0, IF accepts as normal but inst_sram_en=0. IF then delivers fs_inst=32'h0 for that PC, and fs_adef_err sets and stays at 1 until reset.
- FS_ADEF_CHECK_EN, undefined: no alignment check. The address goes out unmodified and fs_adef_err is tied to 0.

## Test plan
- Reset release, ds_allowin=1, SRAM returns addr-based data → IF delivers pcs 1c000000, 1c000004, 1c000008 on consecutive cycles after the 1-cycle latency.
- Stream with ds_allowin=0 for 3 cycles after pc 1c000004 is valid, SRAM rdata changed to garbage → fs_to_ds_bus stays {1c000004, original inst} and no new address is accepted. The next pc is 1c000008 after release.
- br_taken=1, target 1c000100, while IF holds 1c000008 → 1c000008 is still delivered, then the fetch address is 1c000100 and the next pc is 1c000100.
- br_stall=1 for 2 cycles with br_taken=1 → inst_sram_en=0 and the IF state is frozen. On the cycle stall drops, the address is br_target.
- Reset asserted while buf_valid=1 and fs_valid=1 → the next cycle has fs_to_ds_valid=0. The first fetch after release is RESET_PC.
- With FS_ADEF_CHECK_EN, br_target=1c000102 → inst_sram_en=0, the delivered inst is 0 with pc 1c000102, and fs_adef_err=1 stays set. Without the macro, address 1c000102 is issued and the flag stays 0.
